// File: rtl/dm_write_tracer.sv
// dm_write_tracer: passive observer of the data-memory write port.
// Every store seen while trace_en is high is captured into a first-word-
// fall-through FIFO and drained over a valid/ready stream. The processor is
// never stalled: stores that find the FIFO full are dropped, flagged by the
// sticky overflow bit and counted in a saturating drop counter.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running cycle
// counter, a per-entry timestamp and the tr_ts output port.
module dm_write_tracer #(
    parameter int N     = 64,
    parameter int DEPTH = 8
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W  = 32
`endif
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     DM_writeEnable,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [N-1:0]             tr_addr,
    output logic [N-1:0]             tr_data,
    output logic [$clog2(DEPTH):0]   tr_count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]          tr_ts
`endif
);

    localparam int          PW     = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

    logic [N-1:0]  addr_mem_r [DEPTH];
    logic [N-1:0]  data_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          overflow_r;
    logic [15:0]   drop_cnt_r;

    logic push_s;
    logic pop_s;
    logic full_s;
    logic wr_ok_s;
    logic drop_s;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // store when the consumer takes the head on that edge.
    assign push_s  = trace_en & DM_writeEnable;
    assign pop_s   = tr_valid & tr_ready;
    assign full_s  = (count_r == FULL_C);
    assign wr_ok_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    assign tr_valid = (count_r != {(PW+1){1'b0}});
    assign tr_count = count_r;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

    // Entry storage; contents need no reset because tr_valid gates every read.
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok_s) begin
            addr_mem_r[wr_ptr_r] <= DM_addr;
            data_mem_r[wr_ptr_r] <= DM_writeData;
        end
    end

    // Pointers, occupancy and drop bookkeeping.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {(PW+1){1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'h0001;
                end
            end
        end
    end

    // Head entry presented straight from storage, zeroed while empty.
    always_comb begin
        tr_addr = {N{1'b0}};
        tr_data = {N{1'b0}};
        if (tr_valid) begin
            tr_addr = addr_mem_r[rd_ptr_r];
            tr_data = data_mem_r[rd_ptr_r];
        end else begin
            tr_addr = {N{1'b0}};
            tr_data = {N{1'b0}};
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_r;
    logic [TS_W-1:0] ts_mem_r [DEPTH];

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ts_cnt_r <= {TS_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + TS_W'(1);
        end
    end

    // Each accepted store records the counter value of its push edge.
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok_s) begin
            ts_mem_r[wr_ptr_r] <= ts_cnt_r;
        end
    end

    // Head timestamp, zeroed while empty.
    always_comb begin
        tr_ts = {TS_W{1'b0}};
        if (tr_valid) begin
            tr_ts = ts_mem_r[rd_ptr_r];
        end else begin
            tr_ts = {TS_W{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_dm_write_tracer.sv
// Bench for dm_write_tracer: directed scenarios followed by randomized
// traffic. A queue-based reference model updates on each posedge; a monitor
// on the negedge compares every DUT output against the model head/state.
module tb_dm_write_tracer;

    localparam int N     = 64;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic        tr_ready;
    logic        tr_valid;
    logic [63:0] tr_addr;
    logic [63:0] tr_data;
    logic [3:0]  tr_count;
    logic        overflow;
    logic [15:0] drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] tr_ts;
`endif

    always #5 clk = ~clk;

    dm_write_tracer dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .trace_en       (trace_en),
        .DM_writeEnable (we),
        .DM_addr        (addr),
        .DM_writeData   (data),
        .tr_valid       (tr_valid),
        .tr_ready       (tr_ready),
        .tr_addr        (tr_addr),
        .tr_data        (tr_data),
        .tr_count       (tr_count),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .tr_ts          (tr_ts)
`endif
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [31:0] ts;
    } ent_t;

    ent_t        exp_q[$];
    logic        ovf_m  = 1'b0;
    int          drop_m = 0;
    logic [31:0] ts_m   = 32'd0;
    bit          armed  = 1'b0;
    int          tests  = 0;
    int          fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of stores, updated at every sampling edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            ovf_m  <= 1'b0;
            drop_m <= 0;
            ts_m   <= 32'd0;
            armed  <= 1'b1;
        end else begin
            if (exp_q.size() != 0 && tr_ready) begin
                void'(exp_q.pop_front());
            end
            if (trace_en && we) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back('{addr, data, ts_m});
                end else begin
                    ovf_m  <= 1'b1;
                    drop_m <= (drop_m < 65535) ? drop_m + 1 : drop_m;
                end
            end
            ts_m <= ts_m + 32'd1;
        end
    end

    // Monitor: compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            chk("tr_valid", {63'd0, tr_valid}, {63'd0, exp_q.size() != 0});
            chk("tr_count", {60'd0, tr_count}, 64'(exp_q.size()));
            chk("overflow", {63'd0, overflow}, {63'd0, ovf_m});
            chk("drop_cnt", {48'd0, drop_cnt}, 64'(drop_m));
            if (exp_q.size() != 0) begin
                chk("tr_addr", tr_addr, exp_q[0].a);
                chk("tr_data", tr_data, exp_q[0].d);
`ifdef TRACE_TIMESTAMP_EN
                chk("tr_ts", {32'd0, tr_ts}, {32'd0, exp_q[0].ts});
`endif
            end else begin
                chk("tr_addr_idle", tr_addr, 64'd0);
                chk("tr_data_idle", tr_data, 64'd0);
`ifdef TRACE_TIMESTAMP_EN
                chk("tr_ts_idle", {32'd0, tr_ts}, 64'd0);
`endif
            end
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic r, input logic en, input logic w, input logic rdy,
                       input logic [63:0] a, input logic [63:0] d);
        reset    = r;
        trace_en = en;
        we       = w;
        tr_ready = rdy;
        addr     = a;
        data     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdy_pct;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

        // Single store becomes visible right after its edge.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h10, 64'hDEAD);
        chk("t1_count", {60'd0, tr_count}, 64'd1);
        chk("t1_addr", tr_addr, 64'h10);
        chk("t1_data", tr_data, 64'hDEAD);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);

        // Fill to DEPTH, then one more store is dropped.
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h100 + 64'(i * 8), 64'hA000 + 64'(i));
        chk("t2_count_full", {60'd0, tr_count}, 64'd8);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h999, 64'h999);
        chk("t2_overflow", {63'd0, overflow}, 64'd1);
        chk("t2_drop", {48'd0, drop_cnt}, 64'd1);
        chk("t2_count", {60'd0, tr_count}, 64'd8);

        // Full FIFO: push together with pop is accepted.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h700, 64'h777);
        chk("t3_count", {60'd0, tr_count}, 64'd8);
        chk("t3_drop", {48'd0, drop_cnt}, 64'd1);
        chk("t3_head", tr_addr, 64'h108);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);

        // Streaming 20 stores with a toggling consumer; pointers wrap.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 40; i++)
            cyc(1'b0, 1'b1, (i % 2) == 0, (i % 4) < 2, 64'h2000 + 64'(i), 64'hB000 + 64'(i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
        chk("t4_overflow", {63'd0, overflow}, 64'd0);

        // Stores ignored while tracing is disabled.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h3000, 64'h3000);
        chk("t5_count", {60'd0, tr_count}, 64'd0);
        chk("t5_drop", {48'd0, drop_cnt}, 64'd0);

        // Reset with entries held discards them.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h4000 + 64'(i), 64'h40 + 64'(i));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("t6_valid", {63'd0, tr_valid}, 64'd0);
        chk("t6_count", {60'd0, tr_count}, 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h5000, 64'h5555);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);

        // Randomized traffic with varying consumer throughput.
        for (int p = 0; p < 6; p++) begin
            rdy_pct = (p % 3 == 0) ? 20 : ((p % 3 == 1) ? 80 : 50);
            for (int i = 0; i < 100; i++)
                cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < rdy_pct),
                    {$urandom(), $urandom()}, {$urandom(), $urandom()});
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
        chk("final_empty", {63'd0, tr_valid}, 64'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
